ram_burst_reader: RTL and testbench



---
 rtl/ram_burst_reader.sv | 173 +++++++++++++++++
 tb/tb_ram_burst_reader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_burst_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ram_burst_reader: burst read initiator for one banked RAM port.          |
// | Optional macro RD_STRIDE_EN adds a per-burst address stride input.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module ram_burst_reader #(
  parameter int DATA_WIDTH    = 64,
  parameter int ADDRESS_WIDTH = 12,
  parameter int LEN_WIDTH     = 12,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]     length,
`ifdef RD_STRIDE_EN
  input  logic [ADDRESS_WIDTH-1:0] stride,
`endif
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] ram_address,
  output logic                     ram_wr_signal,
  input  logic [DATA_WIDTH-1:0]    ram_data_read,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                  r_state;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [LEN_WIDTH-1:0]    r_issue_cnt;
  logic [LEN_WIDTH-1:0]    r_beat_cnt;
  // bit0: address registered last edge, bit1: its data is on ram_data_read now
  logic [1:0]              r_pipe;

  logic [DATA_WIDTH-1:0]   r_mem [FIFO_DEPTH];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;

  logic [CW-1:0]           w_inflight;
  logic [CW-1:0]           w_used;
  logic                    w_can_issue;
  logic                    w_push;
  logic                    w_pop;
  logic [ADDRESS_WIDTH-1:0] w_step;

`ifdef RD_STRIDE_EN
  logic [ADDRESS_WIDTH-1:0] r_stride;
  assign w_step = r_stride;
`else
  assign w_step = ADDRESS_WIDTH'(1);
`endif

  assign ram_wr_signal = 1'b0;

  // Pops in the current cycle deliberately earn no credit, keeping the check off the ready path.
  assign w_inflight  = CW'(r_pipe[0]) + CW'(r_pipe[1]);
  assign w_used      = r_count + w_inflight;
  assign w_can_issue = (w_used < CW'(FIFO_DEPTH));

  assign w_push    = r_pipe[1];
  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid & out_ready;
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_last  = out_valid && (r_beat_cnt == r_len - LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      ram_address <= '0;
      r_len       <= '0;
      r_issue_cnt <= '0;
      r_beat_cnt  <= '0;
      r_pipe      <= 2'b00;
`ifdef RD_STRIDE_EN
      r_stride    <= '0;
`endif
    end else begin
      r_pipe <= {r_pipe[0], 1'b0};
      done   <= 1'b0;
      if (w_pop) begin
        r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            r_beat_cnt <= '0;
            if (length == '0) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_len       <= length;
              ram_address <= base_addr;
              r_issue_cnt <= LEN_WIDTH'(1);
              r_pipe[0]   <= 1'b1;
`ifdef RD_STRIDE_EN
              r_stride    <= stride;
`endif
              r_state     <= (length == LEN_WIDTH'(1)) ? S_DRAIN : S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (w_can_issue) begin
            ram_address <= ram_address + w_step;
            r_issue_cnt <= r_issue_cnt + LEN_WIDTH'(1);
            r_pipe[0]   <= 1'b1;
            if (r_issue_cnt + LEN_WIDTH'(1) == r_len) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (w_pop && out_last) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage carries no reset; occupancy is governed by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= ram_data_read;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ram_burst_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ram_burst_reader: self-checking bench for ram_burst_reader.           |
// | Honours RD_STRIDE_EN when defined. Revision: 1.0                         |
// +--------------------------------------------------------------------------+
module tb_ram_burst_reader;

  localparam int DW    = 64;
  localparam int AW    = 7;
  localparam int LW    = 12;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] length = '0;
`ifdef RD_STRIDE_EN
  logic [AW-1:0] stride = '0;
`endif
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_address;
  logic          ram_wr_signal;
  logic [DW-1:0] ram_data_read = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;

  logic [DW-1:0] mem [DEPTH];

  int vectors = 0;
  int miscompares = 0;
  bit wr_bad = 1'b0;
  int max_cnt = 0;

  ram_burst_reader #(
    .DATA_WIDTH(DW), .ADDRESS_WIDTH(AW), .LEN_WIDTH(LW), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .length(length),
`ifdef RD_STRIDE_EN
    .stride(stride),
`endif
    .busy(busy), .done(done), .ram_address(ram_address), .ram_wr_signal(ram_wr_signal),
    .ram_data_read(ram_data_read), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Synchronous RAM with one cycle of registered read latency.
  always @(posedge clk) ram_data_read <= mem[ram_address];

  always @(negedge clk) begin
    if (ram_wr_signal !== 1'b0) wr_bad = 1'b1;
    if (int'(dut.r_count) > max_cnt) max_cnt = int'(dut.r_count);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit ready_for(input int mode, input int n);
    bit [5:0] pat;
    pat = 6'b101001;
    case (mode)
      0:       return 1'b1;
      1:       return pat[5 - (n % 6)];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Drives one burst from an idle sample point and checks it against the
  // expected word list: RAM contents at base + i*stride (mod 2^AW).
  task automatic run_burst(input int b, input int len, input int strd, input int rmode,
                           input int exp_done_lat, input bit junk);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] e;
    logic [DW-1:0] prev_data;
    int n, first_valid, done_seen, budget;
    bit last_committed, stall_prev, exp_done;
    for (int i = 0; i < len; i++) exp_q.push_back(mem[(b + i * strd) % DEPTH]);
    start = 1'b1;
    base_addr = AW'(b);
    length = LW'(len);
`ifdef RD_STRIDE_EN
    stride = AW'(strd);
`endif
    tick();
    start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    n = 0; first_valid = -1; done_seen = -1;
    last_committed = 1'b0; stall_prev = 1'b0; prev_data = '0;
    budget = 64 + 16 * len;
    while (done_seen < 0 && n < budget) begin
      exp_done = last_committed || (len == 0 && n == 0);
      chk("done_timing", done, exp_done);
      if (done) done_seen = n;
      if (out_valid && first_valid < 0) first_valid = n;
      if (stall_prev) begin
        chk("stall_valid", out_valid, 1'b1);
        chk("stall_data", out_data, prev_data);
      end
      out_ready = ready_for(rmode, n);
      if (junk) begin
        start = busy && ($urandom_range(0, 2) == 0);
        base_addr = AW'($urandom);
        length = LW'($urandom);
`ifdef RD_STRIDE_EN
        stride = AW'($urandom);
`endif
      end
      last_committed = 1'b0;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", out_data, e);
          chk("beat_last", out_last, exp_q.size() == 0);
          last_committed = (exp_q.size() == 0);
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data = out_data;
      if (done_seen < 0) begin
        tick();
        n++;
      end
    end
    start = 1'b0;
    if (done_seen < 0) chk("done_timeout", 1'b0, 1'b1);
    chk("words_left", exp_q.size(), 0);
    if (len > 0) chk("first_valid_lat", first_valid, 2);
    else         chk("never_valid", first_valid, -1);
    if (exp_done_lat >= 0) chk("done_lat", done_seen, exp_done_lat);
    tick();
    chk("idle_busy", busy, 1'b0);
    chk("idle_done", done, 1'b0);
    chk("idle_valid", out_valid, 1'b0);
  endtask

  typedef struct packed {
    int base;
    int len;
    int rmode;
    int exp_done_lat;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int beats, rlen, rmode, rstr;
    bit quiet_bad;

    for (int i = 0; i < DEPTH; i++) mem[i] = {32'(i * 32'h9E3779B1), 32'(150 + i)};

    tbl[0] = '{10, 4, 0, 6};
    tbl[1] = '{10, 4, 1, -1};
    tbl[2] = '{50, 0, 0, 0};
    tbl[3] = '{126, 4, 0, 6};
    tbl[4] = '{0, 1, 0, 3};
    tbl[5] = '{100, 9, 0, 11};

    repeat (3) tick();
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", ram_address, 0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_data", out_data, 0);
    chk("ram_a0", mem[10][31:0], 32'hA0);
    rst_n = 1'b1;
    tick();

    for (int t = 0; t < 6; t++) begin
      run_burst(tbl[t].base, tbl[t].len, 1, tbl[t].rmode, tbl[t].exp_done_lat, 1'b0);
    end

    // Reset in the middle of a length-8 burst.
    out_ready = 1'b1;
    start = 1'b1; base_addr = AW'(20); length = LW'(8);
`ifdef RD_STRIDE_EN
    stride = AW'(1);
`endif
    tick();
    start = 1'b0;
    beats = 0;
    for (int c = 0; c < 20 && beats < 2; c++) begin
      if (out_valid) begin
        chk("rst_burst_data", out_data, mem[(20 + beats) % DEPTH]);
        beats++;
      end
      tick();
    end
    chk("rst_burst_beats", beats, 2);
    rst_n = 1'b0;
    tick();
    chk("abort_busy", busy, 1'b0);
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_done", done, 1'b0);
    rst_n = 1'b1;
    quiet_bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done || out_valid || busy) quiet_bad = 1'b1;
    end
    chk("abort_quiet", quiet_bad, 1'b0);
    run_burst(0, 2, 1, 0, 4, 1'b0);

`ifdef RD_STRIDE_EN
    run_burst(3, 3, 50, 0, 5, 1'b1);
    run_burst(5, 3, 0, 0, 5, 1'b0);
`endif

    for (int r = 0; r < 12; r++) begin
      rlen  = $urandom_range(0, 20);
      rmode = $urandom_range(0, 2);
`ifdef RD_STRIDE_EN
      rstr  = $urandom_range(0, DEPTH - 1);
`else
      rstr  = 1;
`endif
      run_burst($urandom_range(0, DEPTH - 1), rlen, rstr, rmode,
                (rmode == 0) ? ((rlen == 0) ? 0 : rlen + 2) : -1, 1'b1);
    end

    chk("wr_strobe_low", wr_bad, 1'b0);
    chk("fifo_bound", max_cnt > 4, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
